// File: rtl/color_reduce_config.sv
// Button-driven configuration of per-channel color depth with a paced three-word
// write sequence into the color-reduction datapath.
module color_reduce_config #(
    parameter int WRITE_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    input  logic       btn_apply,
    output logic       select,
    output logic [1:0] selector,
    output logic [2:0] inputVal,
    output logic       busy,
    output logic [1:0] cur_chan,
    output logic [8:0] depths
);

    typedef enum logic [1:0] {IDLE, WR, GAP} state_t;

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_gapCnt;
    logic       r_pending;
    logic       r_select;
    logic [1:0] r_selector;
    logic [2:0] r_inputVal;
    logic       r_busy;
    logic [1:0] r_cur;
    logic [2:0] r_depth [0:2];
    logic [2:0] r_snap  [0:2];

    // Depth edits and cursor moves run independently of the write sequencer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_depth[0] <= 3'd7;
            r_depth[1] <= 3'd7;
            r_depth[2] <= 3'd7;
            r_cur      <= 2'd0;
        end else begin
            if (btn_up && !btn_down && r_depth[r_cur] != 3'd7)
                r_depth[r_cur] <= r_depth[r_cur] + 3'd1;
            else if (btn_down && !btn_up && r_depth[r_cur] != 3'd0)
                r_depth[r_cur] <= r_depth[r_cur] - 3'd1;
            if (btn_next)
                r_cur <= (r_cur == 2'd2) ? 2'd0 : r_cur + 2'd1;
        end
    end

    // Pending starts set so the datapath gets initialised right after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx      <= 2'd0;
            r_gapCnt   <= 4'd0;
            r_pending  <= 1'b1;
            r_select   <= 1'b0;
            r_selector <= 2'd0;
            r_inputVal <= 3'd0;
            r_busy     <= 1'b0;
            r_snap[0]  <= 3'd7;
            r_snap[1]  <= 3'd7;
            r_snap[2]  <= 3'd7;
        end else begin
            r_select <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (btn_apply || r_pending) begin
                        r_state    <= WR;
                        r_busy     <= 1'b1;
                        r_idx      <= 2'd0;
                        r_snap     <= r_depth;
                        r_pending  <= 1'b0;
                        r_select   <= 1'b1;
                        r_selector <= 2'd0;
                        r_inputVal <= r_depth[0];
                    end
                end
                WR: begin
                    r_gapCnt <= 4'(WRITE_GAP - 1);
                    if (r_idx == 2'd2) begin
                        if (btn_apply || r_pending) begin
                            r_state   <= GAP;
                            r_idx     <= 2'd0;
                            r_snap    <= r_depth;
                            r_pending <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_state <= GAP;
                        r_idx   <= r_idx + 2'd1;
                        if (btn_apply)
                            r_pending <= 1'b1;
                    end
                end
                GAP: begin
                    if (btn_apply)
                        r_pending <= 1'b1;
                    // r_idx already points at the next word to write.
                    if (r_gapCnt == 4'd0) begin
                        r_state    <= WR;
                        r_select   <= 1'b1;
                        r_selector <= r_idx;
                        r_inputVal <= r_snap[r_idx];
                    end else begin
                        r_gapCnt <= r_gapCnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign select   = r_select;
    assign selector = r_selector;
    assign inputVal = r_inputVal;
    assign busy     = r_busy;
    assign cur_chan = r_cur;
    assign depths   = {r_depth[0], r_depth[1], r_depth[2]};

endmodule

// File: tb/tb_color_reduce_config.sv
// Scoreboard bench: stimulus queues expected strobes with their cycle numbers,
// a negedge monitor pops and compares each strobe the DUT produces.
module tb_color_reduce_config;

   logic       clock = 1'b0;
   logic       reset;
   logic       btnUp, btnDown, btnNext, btnApply;
   logic       select;
   logic [1:0] selector;
   logic [2:0] inputVal;
   logic       busy;
   logic [1:0] curChan;
   logic [8:0] depths;

   typedef struct {
      logic [1:0] sel;
      logic [2:0] val;
      int         cyc;
   } exp_t;

   exp_t expQ[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   int   n;

   color_reduce_config #(.WRITE_GAP(2)) dut (
      .clk      (clock),
      .reset    (reset),
      .btn_up   (btnUp),
      .btn_down (btnDown),
      .btn_next (btnNext),
      .btn_apply(btnApply),
      .select   (select),
      .selector (selector),
      .inputVal (inputVal),
      .busy     (busy),
      .cur_chan (curChan),
      .depths   (depths)
   );

   // 10 ns clock; cyc counts rising edges so strobe cycles can be predicted.
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: every strobe must match the oldest queued expectation, including its cycle.
   always @(negedge clock) begin
      exp_t e;
      if (select === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_strobe cycle=%0d selector=%0d inputVal=%0d", cyc, selector, inputVal);
         end else begin
            e = expQ.pop_front();
            if (selector !== e.sel || inputVal !== e.val || cyc != e.cyc) begin
               failures++;
               $display("[TB] FAIL strobe got sel=%0d val=%0d cyc=%0d expected sel=%0d val=%0d cyc=%0d",
                        selector, inputVal, cyc, e.sel, e.val, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One-cycle button pulse; the effect is visible when this returns.
   task automatic applyStimulus(input logic up, input logic down, input logic next, input logic apply);
      btnUp = up; btnDown = down; btnNext = next; btnApply = apply;
      tick();
      btnUp = 1'b0; btnDown = 1'b0; btnNext = 1'b0; btnApply = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic pushExp(input logic [1:0] sel, input logic [2:0] val, input int c);
      exp_t e;
      e.sel = sel; e.val = val; e.cyc = c;
      expQ.push_back(e);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_select"},   {8'd0, select},   9'd0);
      checkOutput({tag, "_busy"},     {8'd0, busy},     9'd0);
      checkOutput({tag, "_selector"}, {7'd0, selector}, 9'd0);
      checkOutput({tag, "_inputVal"}, {6'd0, inputVal}, 9'd0);
      checkOutput({tag, "_curChan"},  {7'd0, curChan},  9'd0);
      checkOutput({tag, "_depths"},   depths,           9'b111_111_111);
   endtask

   initial begin
      reset = 1'b0;
      btnUp = 1'b0; btnDown = 1'b0; btnNext = 1'b0; btnApply = 1'b0;
      repeat (3) tick();
      checkResetState("reset");

      // Init sequence after release: strobes at n+1, n+4, n+7.
      reset = 1'b1;
      n = cyc;
      pushExp(2'd0, 3'd7, n + 1);
      pushExp(2'd1, 3'd7, n + 4);
      pushExp(2'd2, 3'd7, n + 7);
      tick();
      checkOutput("init_busy_start", {8'd0, busy}, 9'd1);
      repeat (6) tick();
      checkOutput("init_busy_last", {8'd0, busy}, 9'd1);
      tick();
      checkOutput("init_busy_done", {8'd0, busy}, 9'd0);

      // Lower G by three and apply.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("cur_after_next", {7'd0, curChan}, 9'd1);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("depths_g4", depths, 9'b111_100_111);
      n = cyc;
      pushExp(2'd0, 3'd7, n + 1);
      pushExp(2'd1, 3'd4, n + 4);
      pushExp(2'd2, 3'd7, n + 7);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("apply_busy", {8'd0, busy}, 9'd1);
      repeat (7) tick();
      checkOutput("apply_busy_done", {8'd0, busy}, 9'd0);

      // Saturation and cursor wrap on R.
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("cur_wrap0", {7'd0, curChan}, 9'd0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("sat_high", depths, 9'b111_100_111);
      repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("sat_low", depths, 9'b000_100_111);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("cur_one", {7'd0, curChan}, 9'd1);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("cur_back0", {7'd0, curChan}, 9'd0);

      // Up + next together on B: the edit lands on B before the cursor wraps.
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("cur_two", {7'd0, curChan}, 9'd2);
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("b_three", depths, 9'b000_100_011);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("upnext_depths", depths, 9'b000_100_100);
      checkOutput("upnext_cur", {7'd0, curChan}, 9'd0);

      // Two applies and an R edit mid-sequence: one back-to-back extra sequence.
      n = cyc;
      pushExp(2'd0, 3'd0, n + 1);
      pushExp(2'd1, 3'd4, n + 4);
      pushExp(2'd2, 3'd4, n + 7);
      pushExp(2'd0, 3'd1, n + 10);
      pushExp(2'd1, 3'd4, n + 13);
      pushExp(2'd2, 3'd4, n + 16);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 16; i++) begin
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL queued_busy cycle=%0d got=%b expected=1", cyc, busy);
         end
         btnApply = (i == 2 || i == 5);
         btnUp    = (i == 3);
         tick();
         btnApply = 1'b0;
         btnUp    = 1'b0;
      end
      checkOutput("queued_busy_done", {8'd0, busy}, 9'd0);
      checkOutput("queued_depths", depths, 9'b001_100_100);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("updown_same", depths, 9'b001_100_100);
      repeat (5) tick();
      checkOutput("no_third_seq", {8'd0, busy}, 9'd0);

      // Reset between the 2nd and 3rd strobes aborts the sequence.
      n = cyc;
      pushExp(2'd0, 3'd1, n + 1);
      pushExp(2'd1, 3'd4, n + 4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) tick();
      reset = 1'b0;
      tick();
      checkResetState("abort");
      reset = 1'b1;
      n = cyc;
      pushExp(2'd0, 3'd7, n + 1);
      pushExp(2'd1, 3'd7, n + 4);
      pushExp(2'd2, 3'd7, n + 7);
      repeat (8) tick();
      checkOutput("reinit_busy_done", {8'd0, busy}, 9'd0);
      repeat (3) tick();

      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL missing_strobes got=%0d expected=0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/color_reduce_config.md
COLOR_REDUCE_CONFIG -- requirements
Module: color_reduce_config

Interface
REQ-001 The block SHALL have one parameter: WRITE_GAP, default 2, idle cycles between consecutive write strobes (legal 1..15).
REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_up  in  1  one-cycle debounced pulse; raises the depth code of the cursor channel.
- btn_down  in  1  one-cycle pulse; lowers the depth code of the cursor channel.
- btn_next  in  1  one-cycle pulse; advances the cursor R->G->B->R.
- btn_apply  in  1  one-cycle pulse; requests a write sequence.
- select  out  1  one-cycle write strobe to the color-reduction datapath.
- selector  out  2  target channel of the write: 0=R, 1=G, 2=B.
- inputVal  out  3  depth code written.
- busy  out  1  high while a write sequence runs.
- cur_chan  out  2  cursor channel.
- depths  out  9  {R,G,B} depth codes, 3 bits each, R in [8:6].

Function
REQ-003 The block SHALL hold three 3-bit depth registers and a 2-bit cursor taking only the values 0..2.
REQ-004 btn_up SHALL increment the cursor channel's depth, saturating at 7; btn_down SHALL decrement it, saturating at 0; both in the same cycle SHALL leave it unchanged.
REQ-005 btn_next SHALL advance the cursor, wrapping 2->0; with btn_up/btn_down in the same cycle, the depth edit SHALL hit the pre-advance channel.
REQ-006 Edits and cursor moves SHALL take effect one cycle after the pulse and SHALL be accepted in any state, busy included.
REQ-007 The FSM SHALL have states IDLE, WR and GAP; busy SHALL be 1 exactly when state != IDLE.
REQ-008 IDLE -> WR SHALL occur when btn_apply=1 or pending=1; on this transition the block SHALL:
- set the write index to 0;
- snapshot all three depth registers;
- clear pending.
REQ-009 In WR, select SHALL be 1 for exactly one cycle, with selector = write index and inputVal = snapshot[index].
REQ-010 WR with index < 2 SHALL go to GAP for exactly WRITE_GAP cycles, then to WR with index+1.
REQ-011 WR with index = 2 SHALL go to IDLE, unless pending=1 or btn_apply=1 that cycle; in that case it SHALL go to GAP with index 0, re-snapshot the depths and clear pending.
REQ-012 A btn_apply pulse seen while state != IDLE (outside REQ-011) SHALL set pending; further pulses SHALL NOT queue more than one extra sequence.
REQ-013 Outside WR, select SHALL be 0, and selector/inputVal SHALL hold their last driven values.
REQ-014 Timing for btn_apply in IDLE at cycle n, with G = WRITE_GAP:
- strobes at cycles n+1, n+2+G and n+3+2G;
- busy high from n+1 through n+3+2G inclusive.
REQ-015 Edits during a sequence SHALL NOT alter the values written by that sequence.

Reset
REQ-016 While reset=0 at a rising edge, the block SHALL set:
- state=IDLE, select=0, selector=0, inputVal=0, busy=0;
- cur_chan=0;
- depths=9'b111_111_111;
- pending=1.
REQ-017 Pending=1 out of reset SHALL make the first cycle after release enter WR, so the datapath is initialised to full depth without a button press.
REQ-018 Reset asserted mid-sequence SHALL abort it at the next edge, with no further strobes until the post-reset init sequence.

Verification (WRITE_GAP=2)
REQ-019 Release reset at cycle 0, no buttons -> strobes at cycles 1, 4, 7 with (selector, inputVal) = (0,7), (1,7), (2,7); busy is 0 from cycle 8.
REQ-020 From idle, btn_next x1, btn_down x3, btn_apply -> depths=9'b111_100_111; strobes write (0,7), (1,4), (2,7) with 2 idle cycles between strobes.
REQ-021 btn_up x3 on cursor 0 at depth 7 -> depth stays 7; btn_down x8 -> depth 0, no underflow; btn_next x3 -> cur_chan returns to 0.
REQ-022 btn_apply twice during one sequence, plus one depth edit mid-sequence -> the current sequence writes the old values; exactly one extra sequence follows directly with no IDLE cycle and carries the new value.
REQ-023 btn_up and btn_next in the same cycle on cursor 2 at depth 3 -> B depth 4, cur_chan=0.
REQ-024 reset=0 for one cycle between the 2nd and 3rd strobes -> no 3rd strobe from the aborted sequence; outputs are at reset values; the init sequence of REQ-019 follows.
